// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexing controller for a multi-digit seven-segment display.
// Grants the shared segment bus to one digit at a time, inserts an all-dark
// gap between digits to suppress ghosting, and decodes each digit's hex
// nibble. New contents arrive over a valid/ready handshake into a shadow
// buffer and are committed to the active buffer only at a frame boundary
// (or immediately while idle), so a frame never mixes old and new data.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   enable      1 = scan running, 0 = display dark
//   load_valid  new display data offered
//   load_ready  shadow buffer free (transfer when valid & ready at an edge)
//   load_data   hex nibbles, digit i = bits [4i+3:4i]
//   load_dp     decimal point per digit
//   segments    active-high segments, bit0 = a ... bit6 = g
//   dp_out      decimal point of the driven digit
//   digit_en    one-hot digit select, all zero while dark
//   frame_done  one-cycle pulse after the last digit's blank ends

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  // The counter only has to reach CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_BLANK
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;

  logic [6:0]              segments_q, segments_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    load_ready_q, load_ready_d;

  logic                    accept;
  logic                    commit;
  logic [3:0]              nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Next-state, buffer and handshake logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    frame_done_d  = 1'b0;
    commit        = 1'b0;

    // load_ready mirrors !pending, so accept and commit are mutually exclusive.
    accept = load_valid && load_ready_q;
    if (accept) begin
      shadow_data_d = load_data;
      shadow_dp_d   = load_dp;
      pending_d     = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        commit = pending_q;
        if (enable) begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            commit       = pending_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end

    load_ready_d = !pending_d;
  end

  // Outputs are decoded from next-state values so they register on the
  // same edge as the state change; a frame-end commit is visible at once.
  always_comb begin
    nibble     = active_data_d[{idx_d, 2'b00} +: 4];
    segments_d = 7'h00;
    dp_out_d   = 1'b0;
    digit_en_d = '0;
    if (state_d == ST_SHOW) begin
      segments_d = hex7(nibble);
      dp_out_d   = active_dp_d[idx_d];
      digit_en_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      segments_q    <= 7'h00;
      dp_out_q      <= 1'b0;
      digit_en_q    <= '0;
      frame_done_q  <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      segments_q    <= segments_d;
      dp_out_q      <= dp_out_d;
      digit_en_q    <= digit_en_d;
      frame_done_q  <= frame_done_d;
      load_ready_q  <= load_ready_d;
    end
  end

  assign segments   = segments_q;
  assign dp_out     = dp_out_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK_CYCLES=2
// (24-cycle frame). Expected per-cycle outputs are pushed into a scoreboard
// queue frame by frame and popped as the DUT produces them.

module tb_seg7_scan_ctrl;

  localparam int FRAME = 24;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [6:0]  segments;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DWELL       (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_dp   (load_dp),
    .segments  (segments),
    .dp_out    (dp_out),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  vec_t       vecs [5];
  exp_t       exp_q [$];
  logic [6:0] hex_lut [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] segs_of(input logic [15:0] d);
    segs_of = {hex_lut[d[15:12]], hex_lut[d[11:8]], hex_lut[d[7:4]], hex_lut[d[3:0]]};
  endfunction

  // Queue the expected outputs for the first n samples of a frame.
  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dps,
                            input bit fd_first, input int load_at, input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      int  d;
      bit  show;
      d    = s / 6;
      show = (s % 6) < 4;
      e.en  = show ? (4'b0001 << d) : 4'b0000;
      e.seg = show ? segs[d*7 +: 7] : 7'h00;
      e.dp  = show ? dps[d] : 1'b0;
      e.fd  = (s == 0) && fd_first;
      e.rdy = (load_at < 0) || (s <= load_at);
      exp_q.push_back(e);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("digit_en",   32'(digit_en),   32'(e.en));
      check("segments",   32'(segments),   32'(e.seg));
      check("dp_out",     32'(dp_out),     32'(e.dp));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("load_ready", 32'(load_ready), 32'(e.rdy));
      check("onehot0",    32'($onehot0(digit_en)), 32'd1);
    end
  endtask

  // Runs n cycles of a frame. A load is offered after sample load_at; in
  // hold mode load_valid stays high with fresh data every cycle and only the
  // data offered after sample 0 is expected to be taken.
  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps,
                           input bit fd_first, input int load_at,
                           input logic [15:0] ld_data, input logic [3:0] ld_dp,
                           input bit hold, input int n);
    push_frame(segs, dps, fd_first, load_at, n);
    for (int s = 0; s < n; s++) begin
      tick();
      pop_check();
      if (hold) begin
        load_valid = 1'b1;
        load_data  = (s == 0) ? ld_data : 16'($urandom);
        load_dp    = (s == 0) ? ld_dp : 4'($urandom);
      end else if (s == load_at) begin
        load_valid = 1'b1;
        load_data  = ld_data;
        load_dp    = ld_dp;
      end else begin
        load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h0, h1;
    logic [3:0]  hd0, hd1;

    hex_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs[0] = '{data: 16'h4321, dp: 4'b0001, segs: {7'h66, 7'h4F, 7'h5B, 7'h06}};
    vecs[1] = '{data: 16'hFEDC, dp: 4'b0000, segs: {7'h71, 7'h79, 7'h5E, 7'h39}};
    vecs[2] = '{data: 16'h8888, dp: 4'b1111, segs: {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{data: 16'hA9B0, dp: 4'b1010, segs: {7'h77, 7'h6F, 7'h7C, 7'h3F}};
    vecs[4] = '{data: 16'h7567, dp: 4'b0100, segs: {7'h07, 7'h6D, 7'h7D, 7'h07}};

    // Reset for 3 cycles, release with enable low.
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0;
    repeat (3) tick();
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("idle_digit_en", 32'(digit_en), 32'd0);
    check("idle_segments", 32'(segments), 32'd0);
    check("idle_dp", 32'(dp_out), 32'd0);
    check("idle_frame_done", 32'(frame_done), 32'd0);
    check("idle_ready", 32'(load_ready), 32'd1);

    // Load in IDLE: ready low for exactly one cycle.
    load_valid = 1'b1; load_data = vecs[0].data; load_dp = vecs[0].dp;
    tick();
    check("idle_load_ready_low", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    tick();
    check("idle_load_ready_back", 32'(load_ready), 32'd1);
    check("idle_still_dark", 32'(digit_en), 32'd0);
    $display("load in idle: data=%h dp=%b", vecs[0].data, vecs[0].dp);

    // Table frames: each frame loads the next vector while digit 1 is shown.
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame(vecs[k].segs, vecs[k].dp, k != 0, 6, vecs[k+1].data, vecs[k+1].dp, 1'b0, FRAME);
      $display("frame %0d: shown %h dp %b, loaded %h", k, vecs[k].data, vecs[k].dp, vecs[k+1].data);
    end

    // load_valid held high with changing data: one transfer per frame.
    h0 = 16'($urandom); hd0 = 4'($urandom);
    h1 = 16'($urandom); hd1 = 4'($urandom);
    run_frame(vecs[4].segs, vecs[4].dp, 1'b1, 0, h0, hd0, 1'b1, FRAME);
    $display("hold frame: shown %h, accepted %h", vecs[4].data, h0);
    run_frame(segs_of(h0), hd0, 1'b1, 0, h1, hd1, 1'b1, FRAME);
    $display("hold frame: shown %h, accepted %h", h0, h1);
    run_frame(segs_of(h1), hd1, 1'b1, -1, 16'h0, 4'h0, 1'b0, FRAME);
    $display("frame: shown %h, no load", h1);

    // Drop enable in the blank after digit 2 with a load pending.
    run_frame(segs_of(h1), hd1, 1'b1, 6, vecs[2].data, vecs[2].dp, 1'b0, 17);
    enable = 1'b0;
    tick();
    check("drop_digit_en", 32'(digit_en), 32'd0);
    check("drop_segments", 32'(segments), 32'd0);
    check("drop_frame_done", 32'(frame_done), 32'd0);
    check("drop_pending_kept", 32'(load_ready), 32'd0);
    tick();
    check("drop_idle_commit", 32'(load_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drop_no_frame_done", 32'(frame_done), 32'd0);
      check("drop_dark", 32'(digit_en), 32'd0);
    end
    $display("enable dropped in blank after digit 2, pending data committed in idle");

    // Re-enable: restart at digit 0 with the all-8 pattern for 3 frames.
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_frame(vecs[2].segs, vecs[2].dp, k != 0, -1, 16'h0, 4'h0, 1'b0, FRAME);
      $display("frame all-8 %0d: shown %h dp %b", k, vecs[2].data, vecs[2].dp);
    end

    // Asynchronous reset mid-scan with a load pending.
    run_frame(vecs[2].segs, vecs[2].dp, 1'b1, 2, vecs[0].data, vecs[0].dp, 1'b0, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_digit_en", 32'(digit_en), 32'd0);
    check("async_rst_segments", 32'(segments), 32'd0);
    check("async_rst_dp", 32'(dp_out), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    check("async_rst_ready", 32'(load_ready), 32'd1);
    tick();
    rst = 1'b0;
    $display("async reset mid-scan");

    // Buffers were cleared: every digit shows 0 with no decimal point.
    run_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b0, -1, 16'h0, 4'h0, 1'b0, FRAME);
    $display("frame after reset: shown 0000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
